// File: rtl/power_dac_scheduler.sv
// power_dac_scheduler: soft-start ramping of NCH power-channel setpoints,
// multiplexed onto one shared setpoint DAC through a valid/ready write port.
// Unpowered channels drop to zero at once, and that zero write jumps the queue.
module power_dac_scheduler #(
  parameter int NCH       = 2,
  parameter int VW        = 18,
  parameter int RAMP_STEP = 256,
  parameter int TICK_DIV  = 5000,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    powered,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*VW-1:0] target,
  input  logic              dac_ready,
  output logic              dac_valid,
  output logic [CW-1:0]     dac_chan,
  output logic              dac_mode,
  output logic [VW-1:0]     dac_data,
  output logic [NCH-1:0]    settled
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [VW:0]   STEP_X    = (VW+1)'(RAMP_STEP);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t         state;
  logic [TW-1:0]  tick_count;
  logic           tick;

  logic [VW-1:0]  cur        [NCH];
  logic [VW-1:0]  cur_nxt    [NCH];
  logic [VW-1:0]  tgt        [NCH];
  logic [VW:0]    up_sum     [NCH];
  logic [VW:0]    dn_lim     [NCH];
  logic [VW-1:0]  ramp_val   [NCH];

  logic [NCH-1:0] dirty;
  logic [NCH-1:0] urgent;
  logic [NCH-1:0] dirty_set;
  logic [NCH-1:0] urgent_set;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] grant_clr;
  logic [CW-1:0]  grant_idx;
  logic           grant_any;
  logic [CW-1:0]  last_grant;

  assign tick = (tick_count == TICK_LAST);

  // Free-running ramp-rate divider; wraps on the tick cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + TW'(1);
    end
  end

  // Per-channel next applied value: clamped ramp step on ticks, forced zero when unpowered.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tgt[i]        = target[i*VW +: VW];
      up_sum[i]     = {1'b0, cur[i]} + STEP_X;
      dn_lim[i]     = {1'b0, tgt[i]} + STEP_X;
      ramp_val[i]   = cur[i];
      cur_nxt[i]    = cur[i];
      dirty_set[i]  = 1'b0;
      urgent_set[i] = 1'b0;

      if (cur[i] < tgt[i]) begin
        ramp_val[i] = (up_sum[i] < {1'b0, tgt[i]}) ? up_sum[i][VW-1:0] : tgt[i];
      end else if (cur[i] > tgt[i]) begin
        ramp_val[i] = (dn_lim[i] < {1'b0, cur[i]}) ? (cur[i] - STEP_X[VW-1:0]) : tgt[i];
      end

      if (!powered[i]) begin
        cur_nxt[i] = '0;
        if (cur[i] != '0) begin
          dirty_set[i]  = 1'b1;
          urgent_set[i] = 1'b1;
        end
      end else if (tick && (ramp_val[i] != cur[i])) begin
        cur_nxt[i]   = ramp_val[i];
        dirty_set[i] = 1'b1;
      end
    end
  end

  // Grant selection: lowest urgent channel first, otherwise round-robin after the last grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!grant_any && urgent[i]) begin
        grant_any   = 1'b1;
        grant_idx   = CW'(i);
        grant_oh[i] = 1'b1;
      end
    end
    for (int k = 1; k <= NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!grant_any && dirty[i] && (((int'(last_grant) + k) % NCH) == i)) begin
          grant_any   = 1'b1;
          grant_idx   = CW'(i);
          grant_oh[i] = 1'b1;
        end
      end
    end
  end

  assign grant_clr = (state == IDLE) ? grant_oh : '0;

  // Applied values and pending-write flags; a new change in the grant cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= '0;
      end
      dirty  <= '0;
      urgent <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cur[i] <= cur_nxt[i];
      end
      dirty  <= (dirty  & ~grant_clr) | dirty_set;
      urgent <= (urgent & ~grant_clr) | urgent_set;
    end
  end

  // DAC write arbiter with registered outputs; the word is frozen until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dac_valid  <= 1'b0;
      dac_chan   <= '0;
      dac_mode   <= 1'b0;
      dac_data   <= '0;
      last_grant <= CW'(NCH - 1);
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            dac_valid  <= 1'b1;
            dac_chan   <= grant_idx;
            dac_mode   <= mode[grant_idx];
            dac_data   <= cur[grant_idx];
            last_grant <= grant_idx;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (dac_ready) begin
            dac_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          dac_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // A channel is settled once its target is reached and no write of it is pending or in flight.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      settled[i] = powered[i] && (cur[i] == tgt[i]) && !dirty[i] &&
                   !(dac_valid && (dac_chan == CW'(i)));
    end
  end

endmodule

// File: tb/tb_power_dac_scheduler.sv
// tb_power_dac_scheduler: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a behavioural model of the ramping channels and DAC arbitration.
`timescale 1ns/1ps
module tb_power_dac_scheduler;

  localparam int NCH  = 2;
  localparam int VW   = 18;
  localparam int STEP = 256;
  localparam int TDIV = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NCH-1:0]    powered = '0;
  logic [NCH-1:0]    mode = '0;
  logic [NCH*VW-1:0] target = '0;
  logic              dac_ready = 1'b0;
  logic              dac_valid;
  logic [0:0]        dac_chan;
  logic              dac_mode;
  logic [VW-1:0]     dac_data;
  logic [NCH-1:0]    settled;

  power_dac_scheduler #(
    .NCH(NCH), .VW(VW), .RAMP_STEP(STEP), .TICK_DIV(TDIV)
  ) dut (
    .clk(clk), .rst(rst), .powered(powered), .mode(mode), .target(target),
    .dac_ready(dac_ready), .dac_valid(dac_valid), .dac_chan(dac_chan),
    .dac_mode(dac_mode), .dac_data(dac_data), .settled(settled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int chan;
    int md;
    int data;
  } word_t;

  word_t exp_q[$];
  word_t log_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_hs = 0;

  // Reference model state
  int m_cur[NCH];
  bit m_dirty[NCH];
  bit m_urgent[NCH];
  bit m_busy = 1'b0;
  int m_chan = 0;
  int m_last = NCH - 1;
  int m_cnt = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] pw, input logic [NCH-1:0] md,
                               input int t0, input int t1, input logic rdy, input int cycles);
    powered   = pw;
    mode      = md;
    target    = {VW'(t1), VW'(t0)};
    dac_ready = rdy;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b0;
  endtask

  function automatic word_t getLog(input int k);
    word_t w;
    w = '{-1, -1, -1};
    if (k < log_q.size()) w = log_q[k];
    return w;
  endfunction

  task automatic checkWord(input string name, input int k, input int ch, input int d);
    word_t w;
    w = getLog(k);
    checkOutput({name, "_chan"}, w.chan, ch);
    checkOutput({name, "_data"}, w.data, d);
  endtask

  function automatic int rampTo(input int c, input int t);
    if (c < t) return (c + STEP < t) ? c + STEP : t;
    if (c > t) return (c - STEP > t) ? c - STEP : t;
    return c;
  endfunction

  function automatic int tgtOf(input int ch);
    return int'(target[ch*VW +: VW]);
  endfunction

  // Model: per edge, settle the in-flight word or grant a new one, then apply ramp/power-off.
  always @(posedge clk) begin
    bit tick;
    int g;
    int nv;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_cur[i] = 0;
        m_dirty[i] = 1'b0;
        m_urgent[i] = 1'b0;
      end
      m_busy = 1'b0;
      m_chan = 0;
      m_last = NCH - 1;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      tick = (m_cnt == TDIV - 1);
      g = -1;
      if (m_busy) begin
        if (dac_ready) m_busy = 1'b0;
      end else begin
        for (int i = 0; i < NCH; i++)
          if (g < 0 && m_urgent[i]) g = i;
        for (int k = 1; k <= NCH; k++)
          if (g < 0 && m_dirty[(m_last + k) % NCH]) g = (m_last + k) % NCH;
        if (g >= 0) begin
          exp_q.push_back('{g, int'(mode[g]), m_cur[g]});
          m_dirty[g]  = 1'b0;
          m_urgent[g] = 1'b0;
          m_busy = 1'b1;
          m_chan = g;
          m_last = g;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!powered[i]) begin
          if (m_cur[i] != 0) begin
            m_dirty[i]  = 1'b1;
            m_urgent[i] = 1'b1;
          end
          m_cur[i] = 0;
        end else if (tick) begin
          nv = rampTo(m_cur[i], tgtOf(i));
          if (nv != m_cur[i]) begin
            m_cur[i]   = nv;
            m_dirty[i] = 1'b1;
          end
        end
      end
      m_cnt = (m_cnt + 1) % TDIV;
    end
  end

  // Monitor: compare valid/settled every cycle, the held word while stalled, and pop on handshake.
  always @(negedge clk) begin
    word_t e;
    bit exp_set;
    checkOutput("dac_valid", dac_valid, m_busy);
    for (int i = 0; i < NCH; i++) begin
      exp_set = powered[i] && (m_cur[i] == tgtOf(i)) && !m_dirty[i] && !(m_busy && m_chan == i);
      checkOutput($sformatf("settled%0d", i), settled[i], exp_set);
    end
    if (dac_valid && m_busy && exp_q.size() > 0 && !dac_ready) begin
      checkOutput("hold_data", dac_data, exp_q[0].data);
    end
    if (dac_valid && dac_ready && !rst) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_word", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("word_chan", dac_chan, e.chan);
        checkOutput("word_mode", dac_mode, e.md);
        checkOutput("word_data", dac_data, e.data);
      end
      log_q.push_back('{int'(dac_chan), int'(dac_mode), int'(dac_data)});
      n_hs++;
    end
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by randomized traffic.
  initial begin
    logic [NCH-1:0] pw;
    logic [NCH-1:0] md;
    int t0;
    int t1;
    logic rdy;

    doReset(2);
    rst = 1'b1;
    checkOutput("reset_valid", dac_valid, 0);
    checkOutput("reset_chan", dac_chan, 0);
    checkOutput("reset_mode", dac_mode, 0);
    checkOutput("reset_data", dac_data, 0);
    checkOutput("reset_settled", settled, 0);
    rst = 1'b0;

    // Single channel soft start to 1000
    log_q.delete();
    applyStimulus(2'b01, 2'b00, 1000, 0, 1'b1, 40);
    checkOutput("ramp_count", log_q.size(), 4);
    checkWord("ramp_w0", 0, 0, 256);
    checkWord("ramp_w1", 1, 0, 512);
    checkWord("ramp_w2", 2, 0, 768);
    checkWord("ramp_w3", 3, 0, 1000);
    checkOutput("ramp_settled0", settled[0], 1);

    // Two channels alternating
    doReset(2);
    log_q.delete();
    applyStimulus(2'b11, 2'b10, 300, 300, 1'b1, 30);
    checkOutput("rr_count", log_q.size(), 4);
    checkWord("rr_w0", 0, 0, 256);
    checkWord("rr_w1", 1, 1, 256);
    checkWord("rr_w2", 2, 0, 300);
    checkWord("rr_w3", 3, 1, 300);

    // Power-off priority over a pending channel
    doReset(2);
    applyStimulus(2'b01, 2'b00, 1000, 0, 1'b1, 30);
    checkOutput("pwr_pre_settled0", settled[0], 1);
    applyStimulus(2'b11, 2'b00, 1000, 2000, 1'b0, 10);
    log_q.delete();
    applyStimulus(2'b10, 2'b00, 1000, 2000, 1'b0, 3);
    applyStimulus(2'b10, 2'b00, 1000, 2000, 1'b1, 10);
    checkWord("pwr_w0", 0, 1, 256);
    checkWord("pwr_w1", 1, 0, 0);

    // Long stall keeps the word; next write carries the latest value
    doReset(2);
    log_q.delete();
    applyStimulus(2'b01, 2'b00, 1000, 0, 1'b0, 24);
    checkOutput("stall_valid", dac_valid, 1);
    checkOutput("stall_data", dac_data, 256);
    applyStimulus(2'b01, 2'b00, 1000, 0, 1'b1, 10);
    checkWord("stall_w0", 0, 0, 256);
    checkWord("stall_w1", 1, 0, 1000);

    // Ramp down to a lower target
    log_q.delete();
    applyStimulus(2'b01, 2'b00, 100, 0, 1'b1, 30);
    checkOutput("down_count", log_q.size(), 4);
    checkWord("down_w0", 0, 0, 744);
    checkWord("down_w1", 1, 0, 488);
    checkWord("down_w2", 2, 0, 232);
    checkWord("down_w3", 3, 0, 100);

    // Reset while a write is outstanding
    doReset(2);
    applyStimulus(2'b11, 2'b00, 500, 500, 1'b0, 0);
    for (int i = 0; i < 20 && !dac_valid; i++) begin
      @(posedge clk);
      #2;
    end
    checkOutput("rstw_wait_valid", dac_valid, 1);
    applyStimulus(2'b11, 2'b00, 500, 500, 1'b0, 0);
    doReset(1);
    rst = 1'b1;
    checkOutput("rstw_valid", dac_valid, 0);
    checkOutput("rstw_settled", settled, 0);
    rst = 1'b0;
    log_q.delete();
    applyStimulus(2'b11, 2'b00, 500, 500, 1'b1, 20);
    checkOutput("rstw_first_chan", getLog(0).chan, 0);

    // Randomized traffic
    doReset(2);
    pw = 2'b11; md = 2'b00; t0 = 600; t1 = 900; rdy = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 39) == 0) pw[c] = ~pw[c];
        if ($urandom_range(0, 49) == 0) md[c] = ~md[c];
      end
      if ($urandom_range(0, 29) == 0)
        t0 = ($urandom_range(0, 9) == 0) ? 262143 - int'($urandom_range(0, 600)) : int'($urandom_range(0, 1500));
      if ($urandom_range(0, 29) == 0)
        t1 = ($urandom_range(0, 9) == 0) ? 262143 - int'($urandom_range(0, 600)) : int'($urandom_range(0, 1500));
      rdy = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(pw, md, t0, t1, rdy, 0);
        doReset(1);
      end else begin
        applyStimulus(pw, md, t0, t1, rdy, 1);
      end
    end
    applyStimulus(pw, md, t0, t1, 1'b1, 10);
    checkOutput("random_progress", (n_hs > 50) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
